// File: rtl/sl_pkg.sv
// Shared SL line definitions: transmitter state encoding, line constants and
// the odd-parity helper also used by the receiver checker.
package sl_pkg;

  localparam int   SL_MAX_BITS   = 32;
  localparam logic SL_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_GAP,
    PAR_LOW,
    PAR_GAP,
    STOP_LOW,
    STOP_GAP
  } sl_tx_state_t;

  // Odd parity over the low n bits of data: the returned bit makes the total
  // count of ones (data bits plus parity) odd.
  function automatic logic sl_odd_parity(input logic [SL_MAX_BITS-1:0] data,
                                         input logic [5:0]             n);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < SL_MAX_BITS; i++) begin
      if (i < int'(n)) acc = acc ^ data[i];
    end
    return ~acc;
  endfunction

endpackage

// File: rtl/sl_transmitter_if.sv
// Host request/status handshake plus the two SL pad lines.
interface sl_transmitter_if;
  import sl_pkg::*;

  logic                   start;
  logic [SL_MAX_BITS-1:0] data_in;
  logic [5:0]             bit_count;
  logic                   busy;
  logic                   done;
  logic                   len_err;
  logic                   sl0;
  logic                   sl1;

  // Host side: issues requests, observes status and the line.
  modport master (output start, data_in, bit_count,
                  input  busy, done, len_err, sl0, sl1);

  // Transmitter side.
  modport slave  (input  start, data_in, bit_count,
                  output busy, done, len_err, sl0, sl1);
endinterface

// File: rtl/sl_symbol_timer.sv
// Loadable down-counter timing each pulse/gap symbol. Load with (cycles-1);
// expired is high in the final cycle of the interval.
module sl_symbol_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  // Count down to zero and hold there until the next load.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// SL two-wire transmitter: serialises 1..32 data bits LSB first, an odd
// parity bit and a stop symbol as low pulses separated by both-high gaps.
// All outputs are registered from the next-state decode, so the lines change
// on the same edge the FSM enters a symbol state.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sl_transmitter_if.slave    bus
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  sl_tx_state_t           state_q, state_d;
  logic [SL_MAX_BITS-1:0] shreg_q;
  logic [5:0]             remaining_q;
  logic                   parity_q;

  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expired;
  logic             accept;
  logic             shift;
  logic             len_ok;
  logic             sym_bit;
  logic             done_d, len_err_d, sl0_d, sl1_d;
  logic             busy_q, done_q, len_err_q, sl0_q, sl1_q;

  sl_symbol_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  assign len_ok = (bus.bit_count != 6'd0) && (bus.bit_count <= 6'(SL_MAX_BITS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, timer reload and event decode.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_val  = PULSE_LOAD;
    accept    = 1'b0;
    shift     = 1'b0;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            accept  = 1'b1;
            load    = 1'b1;
            state_d = BIT_LOW;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      BIT_LOW: if (expired) begin
        load = 1'b1; load_val = GAP_LOAD; state_d = BIT_GAP;
      end
      BIT_GAP: if (expired) begin
        shift   = 1'b1;
        load    = 1'b1;
        state_d = (remaining_q == 6'd1) ? PAR_LOW : BIT_LOW;
      end
      PAR_LOW: if (expired) begin
        load = 1'b1; load_val = GAP_LOAD; state_d = PAR_GAP;
      end
      PAR_GAP: if (expired) begin
        load = 1'b1; state_d = STOP_LOW;
      end
      STOP_LOW: if (expired) begin
        load = 1'b1; load_val = GAP_LOAD; state_d = STOP_GAP;
      end
      STOP_GAP: if (expired) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line levels for the state being entered; the symbol bit is looked ahead
  // so it lines up with the shift register update on the same edge.
  always_comb begin
    sym_bit = shreg_q[0];
    if (accept)     sym_bit = bus.data_in[0];
    else if (shift) sym_bit = shreg_q[1];
    if (state_d == PAR_LOW) sym_bit = parity_q;
    sl0_d = SL_IDLE_LEVEL;
    sl1_d = SL_IDLE_LEVEL;
    case (state_d)
      BIT_LOW, PAR_LOW: begin
        if (sym_bit) sl1_d = ~SL_IDLE_LEVEL;
        else         sl0_d = ~SL_IDLE_LEVEL;
      end
      STOP_LOW: begin
        sl0_d = ~SL_IDLE_LEVEL;
        sl1_d = ~SL_IDLE_LEVEL;
      end
      default: ;
    endcase
  end

  // Word datapath: latch on accept, shift and count down after each data gap.
  // NOTE: the shift register is reset along with the control state; it is
  // small and a known value keeps the line decode free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      remaining_q <= '0;
      parity_q    <= 1'b0;
    end else if (accept) begin
      shreg_q     <= bus.data_in;
      remaining_q <= bus.bit_count;
      parity_q    <= sl_odd_parity(bus.data_in, bus.bit_count);
    end else if (shift) begin
      shreg_q     <= shreg_q >> 1;
      remaining_q <= remaining_q - 6'd1;
    end
  end

  // Registered outputs; reset drives the lines high, never low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl0_q     <= SL_IDLE_LEVEL;
      sl1_q     <= SL_IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      sl0_q     <= sl0_d;
      sl1_q     <= sl1_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.sl0     = sl0_q;
  assign bus.sl1     = sl1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.len_err = len_err_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Self-checking bench for sl_transmitter: a line monitor decodes symbols from
// falling edges, and a word model built from the encoding rules supplies the
// expected symbol stream, pulse widths and word duration.
module tb_sl_transmitter;
  import sl_pkg::*;

  localparam int P   = 4;
  localparam int G   = 4;
  localparam int SYM = P + G;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sl_transmitter_if bus ();

  sl_transmitter #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Monitor-owned records (symbol 0 = sl0 pulse, 1 = sl1 pulse, 2 = stop).
  int   sym_q[$];
  int   sym_cyc_q[$];
  int   done_q[$];
  int   low_q[$];
  int   glitches    = 0;
  int   busy_hi     = 0;
  int   len_err_cnt = 0;
  logic prev0 = 1'b1, prev1 = 1'b1;
  int   run0 = 0, run1 = 0;

  int exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev0 && prev1 && !(bus.sl0 && bus.sl1)) begin
      sym_q.push_back((!bus.sl0 && !bus.sl1) ? 2 : (!bus.sl0 ? 0 : 1));
      sym_cyc_q.push_back(cyc);
    end else if ((prev0 && !bus.sl0) || (prev1 && !bus.sl1)) begin
      glitches <= glitches + 1;
    end
    if (bus.sl0 && run0 != 0) low_q.push_back(run0);
    if (bus.sl1 && run1 != 0) low_q.push_back(run1);
    run0 <= bus.sl0 ? 0 : run0 + 1;
    run1 <= bus.sl1 ? 0 : run1 + 1;
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (bus.busy === 1'b1) busy_hi <= busy_hi + 1;
    if (bus.len_err === 1'b1) len_err_cnt <= len_err_cnt + 1;
    prev0 <= bus.sl0;
    prev1 <= bus.sl1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Settle point: just after the falling edge, once the monitor has updated.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected symbol stream for one word from the encoding rules.
  task automatic model_word(input logic [31:0] d, input int n);
    logic [31:0] m;
    int          ones;
    m    = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    ones = $countones(d & m);
    for (int i = 0; i < n; i++) exp_q.push_back(int'(d[i]));
    exp_q.push_back((ones % 2 == 0) ? 1 : 0);
    exp_q.push_back(2);
  endtask

  task automatic pulse_start(input logic [31:0] d, input int n);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.data_in   = d;
    bus.bit_count = 6'(n);
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    check("done_within_budget", done_q.size() >= target, 1'b1);
  endtask

  task automatic check_syms(input string tag, input int sb);
    int got;
    check({tag, "_sym_count"}, sym_q.size() - sb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (sb + i < sym_q.size()) ? sym_q[sb + i] : 255;
      check($sformatf("%s_sym%0d", tag, i), got, exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic check_widths(input string tag, input int lb);
    int bad = 0;
    for (int i = lb; i < low_q.size(); i++) if (low_q[i] != P) bad++;
    check({tag, "_bad_pulse_widths"}, bad, 0);
  endtask

  task automatic run_word(input string tag, input logic [31:0] d, input int n);
    int sb, db, lb, gb, dur;
    sb = sym_q.size(); db = done_q.size(); lb = low_q.size(); gb = glitches;
    model_word(d, n);
    pulse_start(d, n);
    wait_done(db + 1, (n + 2) * SYM + 20);
    tick(); tick();
    check_syms(tag, sb);
    dur = (done_q.size() > db && sym_q.size() > sb) ? done_q[db] - sym_cyc_q[sb] : -1;
    check({tag, "_duration"}, dur, (n + 2) * SYM);
    check({tag, "_done_pulses"}, done_q.size() - db, 1);
    check({tag, "_glitches"}, glitches - gb, 0);
    check({tag, "_busy_after"}, bus.busy, 1'b0);
    check_widths(tag, lb);
  endtask

  initial begin
    int sb, db, lb, bb, eb, gb, k, gap;
    logic [31:0] rd;
    int          rn;

    bus.start     = 1'b0;
    bus.data_in   = '0;
    bus.bit_count = '0;

    // Reset state, checked while reset is held and after release.
    tick(); tick();
    check("rst_sl0", bus.sl0, 1'b1);
    check("rst_sl1", bus.sl1, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_len_err", bus.len_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("idle_sl0", bus.sl0, 1'b1);
    check("idle_busy", bus.busy, 1'b0);

    // Basic word and the widest word.
    run_word("w5", 32'h5, 3);
    run_word("wff", 32'hFFFF_FFFF, 32);

    // Illegal lengths are rejected with a single len_err pulse each.
    sb = sym_q.size(); bb = busy_hi; eb = len_err_cnt;
    pulse_start(32'h1234_5678, 0);
    check("len0_err", bus.len_err, 1'b1);
    check("len0_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("len0_err_clear", bus.len_err, 1'b0);
    pulse_start(32'h1234_5678, 33);
    check("len33_err", bus.len_err, 1'b1);
    repeat (4) tick();
    check("len_err_pulses", len_err_cnt - eb, 2);
    check("len_busy_cycles", busy_hi - bb, 0);
    check("len_no_symbols", sym_q.size() - sb, 0);
    check("len_sl0", bus.sl0, 1'b1);
    check("len_sl1", bus.sl1, 1'b1);

    // start hammered (with changing data) while busy: one word only.
    sb = sym_q.size(); db = done_q.size(); lb = low_q.size();
    model_word(32'hA, 4);
    pulse_start(32'hA, 4);
    k = 0;
    while (done_q.size() == db && k < 6 * SYM + 20) begin
      @(posedge clk); #1;
      if (bus.busy) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.data_in   = $urandom;
        bus.bit_count = 6'($urandom_range(1, 32));
      end else begin
        bus.start = 1'b0;
      end
      k++;
    end
    bus.start = 1'b0;
    repeat (3 * SYM) tick();
    check_syms("busy_start", sb);
    check("busy_start_done_pulses", done_q.size() - db, 1);
    check_widths("busy_start", lb);

    // Reset during the second data bit's low pulse.
    sb = sym_q.size(); db = done_q.size(); gb = glitches;
    pulse_start(32'h6, 3);
    k = 0;
    while (sym_q.size() < sb + 2 && k < 4 * SYM) begin
      tick();
      k++;
    end
    check("mid_rst_reached_bit2", sym_q.size() - sb, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sl0", bus.sl0, 1'b1);
    check("mid_rst_sl1", bus.sl1, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("mid_rst_no_extra_sym", sym_q.size() - sb, 2);
    check("mid_rst_glitches", glitches - gb, 0);
    check("mid_rst_no_done", done_q.size() - db, 0);
    run_word("after_rst", 32'h1, 1);

    // Back-to-back words, second start raised in the cycle done is visible.
    sb = sym_q.size(); db = done_q.size(); lb = low_q.size();
    model_word(32'h3, 2);
    model_word(32'h0, 2);
    pulse_start(32'h3, 2);
    k = 0;
    while (bus.done !== 1'b1 && k < 4 * SYM + 20) begin
      @(negedge clk);
      k++;
    end
    bus.start     = 1'b1;
    bus.data_in   = 32'h0;
    bus.bit_count = 6'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(db + 2, 4 * SYM + 20);
    tick(); tick();
    check_syms("b2b", sb);
    check("b2b_done_pulses", done_q.size() - db, 2);
    gap = (done_q.size() > db && sym_q.size() > sb + 4) ? sym_cyc_q[sb + 4] - done_q[db] : -1;
    check("b2b_restart_gap", gap, 1);
    check_widths("b2b", lb);

    // Randomised words against the model.
    for (int t = 0; t < 4; t++) begin
      rd = $urandom;
      rn = $urandom_range(1, 32);
      run_word($sformatf("rand%0d", t), rd, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sl_transmitter.md
Name: sl_transmitter

Overview:
- Clocked transmitter for the two-wire SL serial line. It drives the sl0/sl1 pair that the SL receiver samples.
- Both lines idle high.
- A low pulse on sl0 encodes bit 0; a low pulse on sl1 encodes bit 1.
- A word is 1..32 data bits sent LSB first, then one odd-parity bit, then a stop symbol (both lines low together).
- The block sits between the register/host side (start/data handshake) and the SL pads. It is also the bench stimulus source for SL receiver verification.

Parameters:
- PULSE_CYCLES, 4, clk cycles a line is held low per symbol (data, parity, stop); legal >= 1.
- GAP_CYCLES, 4, clk cycles both lines are held high after each symbol; legal >= 1.
- CNT_W, 16, width of the internal timing counter; must hold max(PULSE_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- data_in  input  32  word to send; bit 0 is sent first.
- bit_count  input  6  number of data bits, legal 1..32.
- busy  output  1  high from the cycle after an accepted start until the end of the final gap.
- done  output  1  one-cycle pulse at the end of the stop gap.
- len_err  output  1  one-cycle pulse when start is rejected for an illegal bit_count.
- sl0  output  1  line 0, registered, idle 1.
- sl1  output  1  line 1, registered, idle 1.

Behaviour:
- Reset values: sl0=1, sl1=1, busy=0, done=0, len_err=0, FSM=IDLE, all counters 0.
- Reset asserted mid-word:
  - Lines return high asynchronously and the word is abandoned.
  - No falling edge may be generated by the reset itself.
- Start acceptance, in IDLE:
  - start=1 with bit_count in 1..32: latch data_in into the shift register, latch bit_count into the remaining-bit counter.
  - Compute parity = ~^(data_in masked to bit_count bits), i.e. the total count of ones over data+parity is odd.
  - Go to BIT_LOW on the next cycle and set busy=1.
  - start=1 with bit_count 0 or >32: stay IDLE, pulse len_err for one cycle; busy and the lines are unchanged.
- start while busy is ignored: no queuing and no error.
- FSM states and transitions:
  - IDLE -> BIT_LOW on an accepted start.
  - BIT_LOW: drive sl0=0 if the current bit is 0, else sl1=0; the other line stays 1. Hold for PULSE_CYCLES, then go to BIT_GAP.
  - BIT_GAP: both lines 1 for GAP_CYCLES. Shift right and decrement the remaining-bit count. If the count is nonzero go to BIT_LOW, else go to PAR_LOW.
  - PAR_LOW: encode the parity bit as in BIT_LOW for PULSE_CYCLES, then go to PAR_GAP.
  - PAR_GAP: both lines 1 for GAP_CYCLES, then go to STOP_LOW.
  - STOP_LOW: sl0=0 and sl1=0, both driven from the same clock edge, for PULSE_CYCLES. Then go to STOP_GAP.
  - STOP_GAP: both lines 1 for GAP_CYCLES. On the last cycle, pulse done=1, drop busy=0, go to IDLE.
- Both lines are never low together except in STOP_LOW, and every symbol is separated by a both-high gap. This guarantees exactly one falling edge per symbol.
- Word duration: (bit_count+2)*(PULSE_CYCLES+GAP_CYCLES) cycles from the first BIT_LOW cycle to the done pulse.
- Back-to-back transfers: start may be asserted in the same cycle done is seen. It is accepted one cycle later in IDLE, so the minimum inter-word idle is 1 cycle beyond the gap.
- All outputs are registered; no combinational path from start to the lines.

Decomposition:
- Package sl_pkg:
  - State enum sl_tx_state_t {IDLE, BIT_LOW, BIT_GAP, PAR_LOW, PAR_GAP, STOP_LOW, STOP_GAP}.
  - Constants SL_MAX_BITS=32 and SL_IDLE_LEVEL=1'b1.
  - Function sl_odd_parity(data, n), shared with the receiver checker.
- One natural sub-module: sl_symbol_timer, a loadable down-counter that produces a terminal pulse after PULSE_CYCLES or GAP_CYCLES.

Test Plan:
- data_in=0x5, bit_count=3, PULSE=GAP=4:
  - Line falls: sl1, sl0, sl1 (bits 1,0,1), then parity sl1 (two ones -> parity 1), then both low.
  - done is seen 40 cycles after the first BIT_LOW cycle.
  - Paired SL receiver reports dataOut=0x5, bitCount=3, parityValid=1.
- data_in=0xFFFFFFFF, bit_count=32:
  - 32 sl1 pulses, then parity sl1 (32 ones -> parity 1), then stop.
  - Receiver dataOut=0xFFFFFFFF.
- bit_count=0, then bit_count=33, each with start:
  - len_err pulses once each.
  - busy stays 0 and sl0=sl1=1 throughout.
- start pulsed repeatedly during a transfer of 0xA, bit_count=4:
  - Exactly one word is emitted: 0,1,0,1 then parity 1.
  - done pulses once.
- rst_n low during the 2nd data bit's BIT_LOW:
  - sl0/sl1 go to 1 within the reset assertion with no extra falling edge; busy=0.
  - After release, a new start with 0x1, bit_count=1 sends sl1, parity sl0, stop.
- Two back-to-back words (0x3/2 bits, then 0x0/2 bits), with the second start asserted in the done cycle:
  - Both words are emitted without overlap; done pulses twice.
